// File: rtl/spi_reg_pkg.sv
// Shared definitions for the SPI register slave: frame FSM states and
// the command / header constants decoded from each frame.
package spi_reg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    NUM,
    CMD,
    ADRH,
    ADRL,
    DATA,
    DONE
  } state_e;

  localparam logic [7:0] CMD_WR    = 8'h55;
  localparam logic [7:0] CMD_RD    = 8'hAA;
  localparam logic [7:0] HDR_BYTES = 8'd4;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an asynchronous SPI line plus rise/fall detect
// on the synchronized copy. Flops reset to the idle line level.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rstb,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q, sync_q, prev_q;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      prev_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign q_o    = sync_q;
  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/spi_reg_slave.sv
// SPI mode-3 slave that turns NUM/CMD/ADDR/data frames into single-cycle
// register bus writes and prefetched reads, with address auto-increment.
module spi_reg_slave
  import spi_reg_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              scs,
  input  logic              sck,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              busy
);

  localparam int BW = $clog2(DATA_W);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

  logic scsS, scsRise, scsFall;
  logic sckS, sckRise, sckFall;
  logic mosiM_q, mosiS_q;
  logic unused;

  state_e            state_q;
  logic [BW-1:0]     bitCnt_q;
  logic [DATA_W-1:0] shift_q, tx_q;
  logic [7:0]        num_q, cmd_q, byteCnt_q;
  logic [ADDR_W-1:0] addr_q, reg_addr_q;
  logic [DATA_W-1:0] reg_wdata_q;
  logic              reg_we_q, reg_re_q, rdCap_q, miso_q, oe_q, busy_q;

  logic [DATA_W-1:0] shift_d;
  logic [ADDR_W-1:0] addrShift_d, addrInc_d;
  logic [7:0]        byteCntInc_d, dataLeft_d;
  logic              byteDone_d;

  spi_sync_edge #(.RST_VAL(1'b1)) u_scs_sync (
    .clk(clk), .rstb(rstb), .d_i(scs), .q_o(scsS), .rise_o(scsRise), .fall_o(scsFall)
  );

  spi_sync_edge #(.RST_VAL(1'b1)) u_sck_sync (
    .clk(clk), .rstb(rstb), .d_i(sck), .q_o(sckS), .rise_o(sckRise), .fall_o(sckFall)
  );

  assign unused = ^{scsRise, sckS};

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      mosiM_q <= 1'b1;
      mosiS_q <= 1'b1;
    end else begin
      mosiM_q <= mosi;
      mosiS_q <= mosiM_q;
    end
  end

  always_comb begin
    shift_d      = {shift_q[DATA_W-2:0], mosiS_q};
    addrShift_d  = {addr_q[ADDR_W-DATA_W-1:0], shift_d};
    addrInc_d    = addr_q + 1'b1;
    byteCntInc_d = byteCnt_q + 8'd1;
    dataLeft_d   = num_q - HDR_BYTES;
    byteDone_d   = sckRise && (bitCnt_q == BIT_LAST);
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q     <= IDLE;
      bitCnt_q    <= '0;
      shift_q     <= '0;
      tx_q        <= '0;
      num_q       <= '0;
      cmd_q       <= '0;
      byteCnt_q   <= '0;
      addr_q      <= '0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_we_q    <= 1'b0;
      reg_re_q    <= 1'b0;
      rdCap_q     <= 1'b0;
      miso_q      <= 1'b0;
      oe_q        <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      reg_we_q <= 1'b0;
      reg_re_q <= 1'b0;
      rdCap_q  <= reg_re_q;
      // Chip select released: abandon the frame and any partial byte at once.
      if (state_q != IDLE && scsS) begin
        state_q  <= IDLE;
        busy_q   <= 1'b0;
        bitCnt_q <= '0;
        shift_q  <= '0;
        tx_q     <= '0;
        miso_q   <= 1'b0;
        oe_q     <= 1'b0;
      end else if (state_q == IDLE) begin
        if (scsFall) begin
          state_q  <= NUM;
          busy_q   <= 1'b1;
          bitCnt_q <= '0;
          shift_q  <= '0;
        end
      end else begin
        if (sckRise) begin
          shift_q  <= shift_d;
          bitCnt_q <= bitCnt_q + 1'b1;
        end
        if (byteDone_d) begin
          case (state_q)
            NUM: begin
              num_q   <= shift_d[7:0];
              state_q <= CMD;
            end
            CMD: begin
              cmd_q   <= shift_d[7:0];
              state_q <= (num_q < HDR_BYTES) ? DONE : ADRH;
            end
            ADRH: begin
              addr_q  <= addrShift_d;
              state_q <= ADRL;
            end
            ADRL: begin
              addr_q    <= addrShift_d;
              byteCnt_q <= '0;
              if (num_q == HDR_BYTES) begin
                state_q <= DONE;
              end else begin
                state_q <= DATA;
                if (cmd_q == CMD_RD) begin
                  reg_re_q   <= 1'b1;
                  reg_addr_q <= addrShift_d;
                  oe_q       <= 1'b1;
                end
              end
            end
            DATA: begin
              addr_q    <= addrInc_d;
              byteCnt_q <= byteCntInc_d;
              if (cmd_q == CMD_WR) begin
                reg_we_q    <= 1'b1;
                reg_addr_q  <= addr_q;
                reg_wdata_q <= shift_d;
              end
              if (byteCntInc_d == dataLeft_d) begin
                state_q <= DONE;
                oe_q    <= 1'b0;
                miso_q  <= 1'b0;
              end else if (cmd_q == CMD_RD) begin
                reg_re_q   <= 1'b1;
                reg_addr_q <= addrInc_d;
              end
            end
            default: ;
          endcase
        end
        // The first fall of each read byte keeps the freshly loaded MSB on miso.
        if (state_q == DATA && cmd_q == CMD_RD && !byteDone_d) begin
          if (rdCap_q) begin
            tx_q   <= reg_rdata;
            miso_q <= reg_rdata[DATA_W-1];
          end else if (sckFall && bitCnt_q != '0) begin
            tx_q   <= tx_q << 1;
            miso_q <= tx_q[DATA_W-2];
          end
        end
      end
    end
  end

  assign miso      = miso_q;
  assign miso_oe   = oe_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_we    = reg_we_q;
  assign reg_re    = reg_re_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_spi_reg_slave.sv
// Scoreboard bench for spi_reg_slave: a mode-3 SPI master drives directed
// frames while a monitor compares register strobes and miso bytes against queues.
module tb_spi_reg_slave;

  localparam int HP = 60;

  typedef struct packed {
    logic        isWrite;
    logic [15:0] addr;
    logic [7:0]  data;
  } strobe_t;

  logic        clk = 1'b0;
  logic        rstb, scs, sck, mosi;
  logic        miso, miso_oe, reg_we, reg_re, busy;
  logic [15:0] reg_addr;
  logic [7:0]  reg_wdata;
  logic [7:0]  reg_rdata = 8'h00;

  strobe_t     expStrobeQ[$];
  logic [7:0]  expMisoQ[$];
  logic [7:0]  gotMisoQ[$];
  logic [7:0]  frameQ[$];
  strobe_t     actStrobe, expStrobe;
  logic [7:0]  gotByte, expByte;
  int          total = 0;
  int          bad = 0;
  int          strayCnt = 0;
  bit          oeSeen = 1'b0;

  always #5 clk = ~clk;

  spi_reg_slave #(.ADDR_W(16), .DATA_W(8)) dut (
    .clk(clk), .rstb(rstb), .scs(scs), .sck(sck), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_we(reg_we), .reg_re(reg_re), .reg_rdata(reg_rdata), .busy(busy)
  );

  // Register file model: read data appears one clock after the read strobe.
  function automatic logic [7:0] rdModel(input logic [15:0] a);
    return (a == 16'h1023) ? 8'h5A : (a[7:0] ^ 8'h3C);
  endfunction

  always @(posedge clk) reg_rdata <= reg_re ? rdModel(reg_addr) : 8'h00;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  // Monitor pops the scoreboard whenever the DUT presents a strobe or a miso byte completes.
  always @(negedge clk) begin
    if (miso_oe) oeSeen = 1'b1;
    if ((!miso_oe && miso) || (reg_we && reg_re)) strayCnt++;
    if (reg_we || reg_re) begin
      actStrobe = '{reg_we, reg_addr, reg_we ? reg_wdata : 8'h00};
      if (expStrobeQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL strobe unexpected: got %h required none", actStrobe);
      end else begin
        expStrobe = expStrobeQ.pop_front();
        checkOutput("strobe", 32'(actStrobe), 32'(expStrobe));
      end
    end
    if (gotMisoQ.size() != 0) begin
      gotByte = gotMisoQ.pop_front();
      if (expMisoQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL miso byte unexpected: got %h required none", gotByte);
      end else begin
        expByte = expMisoQ.pop_front();
        checkOutput("miso byte", 32'(gotByte), 32'(expByte));
      end
    end
  end

  task automatic expW(input logic [15:0] a, input logic [7:0] d);
    expStrobeQ.push_back('{1'b1, a, d});
  endtask

  task automatic expR(input logic [15:0] a);
    expStrobeQ.push_back('{1'b0, a, 8'h00});
  endtask

  task automatic sendByte(input logic [7:0] b, input int nBits, input bit cap);
    logic [7:0] rx = 8'h00;
    for (int i = 7; i >= 8 - nBits; i--) begin
      sck  = 1'b0;
      mosi = b[i];
      #HP;
      sck   = 1'b1;
      rx[i] = miso;
      #HP;
    end
    if (cap) gotMisoQ.push_back(rx);
  endtask

  // Drives frameQ inside one scs-low window; the final byte may be cut short.
  task automatic applyStimulus(input int capFrom, input int lastBits);
    oeSeen   = 1'b0;
    strayCnt = 0;
    scs      = 1'b0;
    #40;
    checkOutput("busy in frame", 32'(busy), 32'd1);
    for (int k = 0; k < frameQ.size(); k++)
      sendByte(frameQ[k], (k == frameQ.size() - 1) ? lastBits : 8, k >= capFrom);
    #40;
  endtask

  task automatic endFrame(input bit expOe);
    @(posedge clk);
    #1 scs = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("busy 3clk after scs rise", 32'(busy), 32'd0);
    repeat (8) @(posedge clk);
    #1;
    checkOutput("strobes pending", 32'(expStrobeQ.size()), 32'd0);
    checkOutput("miso bytes pending", 32'(expMisoQ.size()), 32'd0);
    checkOutput("miso_oe seen", 32'(oeSeen), 32'(expOe));
    checkOutput("stray miso or strobe clash", 32'(strayCnt), 32'd0);
  endtask

  task automatic resetCheck(input string tag);
    checkOutput({tag, " miso"}, 32'(miso), 32'd0);
    checkOutput({tag, " miso_oe"}, 32'(miso_oe), 32'd0);
    checkOutput({tag, " reg_we"}, 32'(reg_we), 32'd0);
    checkOutput({tag, " reg_re"}, 32'(reg_re), 32'd0);
    checkOutput({tag, " reg_addr"}, 32'(reg_addr), 32'd0);
    checkOutput({tag, " reg_wdata"}, 32'(reg_wdata), 32'd0);
    checkOutput({tag, " busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rstb = 1'b0;
    scs  = 1'b1;
    sck  = 1'b1;
    mosi = 1'b1;
    #23;
    resetCheck("por");
    rstb = 1'b1;
    repeat (5) @(posedge clk);
    #2;

    expW(16'h1023, 8'h18);
    frameQ = '{8'h05, 8'h55, 8'h10, 8'h23, 8'h18};
    applyStimulus(99, 8);
    endFrame(1'b0);

    expR(16'h1023);
    expMisoQ.push_back(8'h5A);
    frameQ = '{8'h05, 8'hAA, 8'h10, 8'h23, 8'h00};
    applyStimulus(4, 8);
    endFrame(1'b1);

    expW(16'hFFFE, 8'h20);
    expW(16'hFFFF, 8'h21);
    expW(16'h0000, 8'h22);
    frameQ = '{8'h07, 8'h55, 8'hFF, 8'hFE, 8'h20, 8'h21, 8'h22};
    applyStimulus(99, 8);
    endFrame(1'b0);

    expW(16'h0010, 8'hAB);
    frameQ = '{8'h06, 8'h55, 8'h00, 8'h10, 8'hAB, 8'hCD};
    applyStimulus(99, 4);
    endFrame(1'b0);

    expW(16'h1234, 8'h77);
    frameQ = '{8'h05, 8'h55, 8'h12, 8'h34, 8'h77};
    applyStimulus(99, 8);
    endFrame(1'b0);

    frameQ = '{8'h05, 8'hAF, 8'h10, 8'h23, 8'h00};
    applyStimulus(99, 8);
    endFrame(1'b0);

    frameQ = '{8'h03, 8'h55, 8'h00};
    applyStimulus(99, 8);
    endFrame(1'b0);

    frameQ = '{8'h04, 8'h55, 8'h00, 8'h00};
    applyStimulus(99, 8);
    endFrame(1'b0);

    expR(16'hFFFF);
    expR(16'h0000);
    expR(16'h0001);
    expMisoQ.push_back(8'hC3);
    expMisoQ.push_back(8'h3C);
    expMisoQ.push_back(8'h3D);
    frameQ = '{8'h07, 8'hAA, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00};
    applyStimulus(4, 8);
    endFrame(1'b1);

    expR(16'h2000);
    frameQ = '{8'h05, 8'hAA, 8'h20, 8'h00, 8'h00};
    applyStimulus(99, 3);
    #3 rstb = 1'b0;
    #1 resetCheck("mid-read rst");
    scs  = 1'b1;
    sck  = 1'b1;
    mosi = 1'b1;
    #50 rstb = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("strobes pending after rst", 32'(expStrobeQ.size()), 32'd0);

    expW(16'hABCD, 8'h99);
    frameQ = '{8'h05, 8'h55, 8'hAB, 8'hCD, 8'h99};
    applyStimulus(99, 8);
    endFrame(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_reg_slave.md
SPI_REG_SLAVE -- requirements
Module: spi_reg_slave

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, meaning the register address width.
REQ-002 The block SHALL have parameter DATA_W, default 8, meaning the register data width and the SPI byte width.
REQ-003 Port clk SHALL be an input of width 1: the single system clock (65 MHz in the board build); all logic is on its rising edge.
REQ-004 Port rstb SHALL be an input of width 1: asynchronous, active-low reset.
REQ-005 Port scs SHALL be an input of width 1: SPI chip select, active low, asynchronous to clk.
REQ-006 Port sck SHALL be an input of width 1: SPI clock, idle high, asynchronous to clk.
REQ-007 Port mosi SHALL be an input of width 1: master-out serial data, MSB first.
REQ-008 Port miso SHALL be an output of width 1: slave-out serial data.
REQ-009 Port miso_oe SHALL be an output of width 1: high while miso must be driven onto the pad.
REQ-010 Port reg_addr SHALL be an output of width ADDR_W: register bus address.
REQ-011 Port reg_wdata SHALL be an output of width 8: register write data.
REQ-012 Port reg_we SHALL be an output of width 1: one-clk write strobe.
REQ-013 Port reg_re SHALL be an output of width 1: one-clk read strobe.
REQ-014 Port reg_rdata SHALL be an input of width 8: read data, valid exactly 1 clk after reg_re.
REQ-015 Port busy SHALL be an output of width 1: high while a frame is in progress (scs low).

Function
REQ-016 scs, sck and mosi SHALL each pass through a 2-flop synchronizer; sck rise and fall SHALL be detected on the synchronized copies.
REQ-017 SPI mode 3 SHALL be used: mosi is sampled on the sck rise; miso changes on the sck fall. Minimum sck half-period: 4 clk.
REQ-018 Frame format SHALL be NUM, CMD, ADDR[15:8], ADDR[7:0], then NUM-4 data bytes, all within one scs-low window.
REQ-019 The FSM states SHALL be IDLE -> NUM -> CMD -> ADRH -> ADRL -> DATA -> DONE.
REQ-020 The scs falling edge SHALL move IDLE to NUM; each 8th sampled bit SHALL advance one state.
REQ-021 From ADRL, the FSM SHALL enter DONE if NUM=4, otherwise DATA.
REQ-022 In DATA, a byte counter SHALL count to NUM-4 and then the FSM SHALL go to DONE; further bytes in DONE SHALL be ignored.
REQ-023 CMD 0x55 SHALL be a write: on each complete data byte, reg_we SHALL be pulsed for 1 clk, 1-2 clk after the 8th sck rise is detected, with reg_addr=ADDR+index and reg_wdata=the byte.
REQ-024 CMD 0xAA SHALL be a read: 1 clk after ADRL completes, reg_re SHALL pulse with reg_addr=ADDR.
REQ-025 For a read, reg_rdata SHALL be captured 1 clk after reg_re into the tx buffer, and its MSB SHALL appear on miso before the first sck fall of the data byte.
REQ-026 For a read, the next address prefetch (ADDR+index+1) SHALL be issued after bit 0 of each data byte is shifted out, if bytes remain.
REQ-027 In a read, the data bytes on mosi SHALL be ignored.
REQ-028 Any other CMD value (including 0xAC and 0xAF) SHALL cause no register access and miso=0 for the rest of the frame.
REQ-029 NUM<4 SHALL be treated as a malformed frame: FSM to DONE after CMD, no access.
REQ-030 Address auto-increment SHALL wrap modulo 2^ADDR_W (0xFFFF+1 -> 0x0000).
REQ-031 The byte counter SHALL be 8 bits; NUM=255 SHALL yield 251 data bytes.
REQ-032 scs rising at any point SHALL return the FSM to IDLE within 3 clk, discard any partial byte, and issue no further strobes.
REQ-033 A strobe already issued before that scs rise SHALL complete normally.
REQ-034 miso_oe SHALL be high only in DATA of a read command; miso SHALL be 0 whenever miso_oe is low.
REQ-035 reg_we and reg_re SHALL never both be high in the same clk.
REQ-036 reg_addr SHALL hold its value between strobes.

Reset
REQ-037 When rstb is low, all state SHALL clear asynchronously: FSM=IDLE, shift registers and counters 0, reg_addr=0, reg_wdata=0, reg_we=0, reg_re=0, miso=0, miso_oe=0, busy=0.
REQ-038 The synchronizer flops SHALL reset to the idle line levels: scs=1, sck=1, mosi=1.

Structure
REQ-039 Package spi_reg_pkg SHALL hold the FSM state enum and the constants CMD_WR=8'h55, CMD_RD=8'hAA, HDR_BYTES=4.
REQ-040 One sub-module, spi_sync_edge, SHALL hold the 2-flop synchronizer plus rise/fall detect and be instantiated for scs and sck; mosi uses the synchronizer only.

Verification
REQ-041 Write frame 05 55 10 23 18 -> exactly one reg_we, reg_addr=0x1023, reg_wdata=0x18.
REQ-042 Read frame 05 AA 10 23 00 with the model returning 0x5A -> one reg_re at 0x1023; miso bits 0,1,0,1,1,0,1,0 on the data-byte sck rises; no reg_we.
REQ-043 Burst write 07 55 FF FE 20 21 22 -> writes to 0xFFFE=0x20, 0xFFFF=0x21, 0x0000=0x22 (wrap).
REQ-044 Write frame 06 55 00 10 …, scs released after 4 bits of the 2nd data byte -> one write only (0x0010); FSM in IDLE within 3 clk; a following valid frame works.
REQ-045 Frames 05 AF 10 23 00 and 03 55 00 -> zero strobes, miso_oe low throughout.
REQ-046 Assert rstb low mid-read -> all outputs return to their reset values immediately; the next frame decodes correctly.
